snitch_fpu_issue: RTL

//  Initiator side of the FPU request/response tag protocol. Accepts decoded FP ops from the core and issues them to the FPU wrapper.

---
 rtl/snitch_pkg.sv | 47 ++++
 rtl/snitch_fpu_issue_if.sv | 70 +++++++
 rtl/snitch_fpu_scoreboard.sv | 57 +++++
 rtl/snitch_fpu_issue.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/snitch_pkg.sv
// Shared types for the Snitch FPU issue slice.
//   fpu_op_e  : FPU operation encoding carried in the request
//   fpu_req_t : op / op_mod / rounding / format fields forwarded to the FPU
//   fpu_tag_t : {rd_int, rd}; selects the destination register file and index
//   tag_idx() : flattens a tag into an index of the 64-entry busy vector
package snitch_pkg;

  localparam int unsigned NumTags = 64;  // 2 register files x 32 registers
  localparam int unsigned NumSrc  = 3;

  typedef enum logic [3:0] {
    FPU_FMADD    = 4'd0,
    FPU_FNMSUB   = 4'd1,
    FPU_ADD      = 4'd2,
    FPU_MUL      = 4'd3,
    FPU_DIV      = 4'd4,
    FPU_SQRT     = 4'd5,
    FPU_SGNJ     = 4'd6,
    FPU_MINMAX   = 4'd7,
    FPU_CMP      = 4'd8,
    FPU_CLASSIFY = 4'd9,
    FPU_F2F      = 4'd10,
    FPU_F2I      = 4'd11,
    FPU_I2F      = 4'd12
  } fpu_op_e;

  typedef struct packed {
    fpu_op_e     op;
    logic        op_mod;
    logic [2:0]  rnd_mode;
    logic [2:0]  src_fmt;
    logic [2:0]  dst_fmt;
    logic [1:0]  int_fmt;
    logic        vectorial_op;
  } fpu_req_t;

  typedef struct packed {
    logic       rd_int;
    logic [4:0] rd;
  } fpu_tag_t;

  // Integer-file tags occupy the upper half of the busy vector.
  function automatic logic [5:0] tag_idx(input fpu_tag_t t);
    return {t.rd_int, t.rd};
  endfunction

endpackage

// File: rtl/snitch_fpu_issue_if.sv
// Bundle of all handshake/bus signals around the FPU issue unit.
//   acc_*      : decoded FP op from the core (valid/ready)
//   fpu_req_*  : request towards the FPU wrapper (valid/ready)
//   fpu_rsp_*  : tagged result from the FPU wrapper (valid/ready)
//   fpr_*      : FP register file write port (write enable only, no backpressure)
//   int_*      : integer writeback (valid/ready)
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where both valid and ready are 1; valid never depends on ready.
// Modports: master = issue unit, slave = core/FPU/regfile environment.
interface snitch_fpu_issue_if
  import snitch_pkg::*;
#(
  parameter int unsigned FLEN = 64
) ();

  logic                      acc_valid;
  logic                      acc_ready;
  fpu_req_t                  acc_op;
  logic [2:0][FLEN-1:0]      acc_operands;
  logic [2:0][4:0]           acc_rs;
  logic [2:0]                acc_rs_fp;
  logic [4:0]                acc_rd;
  logic                      acc_rd_int;

  logic                      fpu_req_valid;
  logic                      fpu_req_ready;
  fpu_req_t                  fpu_req;
  logic [2:0][FLEN-1:0]      fpu_operands;
  fpu_tag_t                  fpu_req_tag;

  logic                      fpu_rsp_valid;
  logic                      fpu_rsp_ready;
  logic [FLEN-1:0]           fpu_result;
  logic [4:0]                fpu_status;
  fpu_tag_t                  fpu_rsp_tag;

  logic                      fpr_we;
  logic [4:0]                fpr_waddr;
  logic [FLEN-1:0]           fpr_wdata;

  logic                      int_valid;
  logic                      int_ready;
  logic [4:0]                int_waddr;
  logic [31:0]               int_wdata;

  modport master (
    input  acc_valid, acc_op, acc_operands, acc_rs, acc_rs_fp, acc_rd, acc_rd_int,
    output acc_ready,
    output fpu_req_valid, fpu_req, fpu_operands, fpu_req_tag,
    input  fpu_req_ready,
    input  fpu_rsp_valid, fpu_result, fpu_status, fpu_rsp_tag,
    output fpu_rsp_ready,
    output fpr_we, fpr_waddr, fpr_wdata,
    output int_valid, int_waddr, int_wdata,
    input  int_ready
  );

  modport slave (
    output acc_valid, acc_op, acc_operands, acc_rs, acc_rs_fp, acc_rd, acc_rd_int,
    input  acc_ready,
    input  fpu_req_valid, fpu_req, fpu_operands, fpu_req_tag,
    output fpu_req_ready,
    output fpu_rsp_valid, fpu_result, fpu_status, fpu_rsp_tag,
    input  fpu_rsp_ready,
    input  fpr_we, fpr_waddr, fpr_wdata,
    input  int_valid, int_waddr, int_wdata,
    output int_ready
  );

endinterface

// File: rtl/snitch_fpu_scoreboard.sv
// Busy-bit scoreboard for pending FPU destinations (32 FP + 32 int registers).
//   clk_i, rst_ni          : clock, async active-low reset
//   set_i, set_tag_i       : mark a destination busy (issue)
//   clr_i, clr_tag_i       : mark a destination free (retire)
//   rs_i, rs_fp_i, dst_i   : hazard query for one candidate op
//   hazard_o               : RAW on any FP source or WAW on the destination
//   clr_busy_o             : current busy bit of clr_tag_i (retire sanity)
//   busy_o                 : full busy vector, index = {rd_int, rd}
module snitch_fpu_scoreboard
  import snitch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  fpu_tag_t        set_tag_i,
  input  logic            clr_i,
  input  fpu_tag_t        clr_tag_i,
  input  logic [2:0][4:0] rs_i,
  input  logic [2:0]      rs_fp_i,
  input  fpu_tag_t        dst_i,
  output logic            hazard_o,
  output logic            clr_busy_o,
  output logic [63:0]     busy_o
);

  logic [NumTags-1:0] busy_q, busy_d;
  logic [NumTags-1:0] set_mask, clr_mask;
  logic               raw;

  // A set and a clear in the same cycle never target the same bit: the
  // destination check below stalls any op whose rd is still pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_i) set_mask[tag_idx(set_tag_i)] = 1'b1;
    if (clr_i) clr_mask[tag_idx(clr_tag_i)] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Sources only ever read the FP file; integer sources come from the core.
  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < NumSrc; k++) begin
      raw = raw | (rs_fp_i[k] & busy_q[{1'b0, rs_i[k]}]);
    end
    hazard_o = raw | busy_q[tag_idx(dst_i)];
  end

  assign clr_busy_o = busy_q[tag_idx(clr_tag_i)];
  assign busy_o     = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/snitch_fpu_issue.sv
// Initiator side of the FPU request/response tag protocol.
// Issues decoded FP ops to the FPU with tag {rd_int, rd}, tracks pending
// destinations in a scoreboard, retires results into the FP regfile or the
// integer writeback port and accumulates sticky fflags.
//   clk_i, rst_ni   : clock, async active-low reset
//   bus (master)    : acc / fpu request / fpu response / fpr / int signals
//   fflags_clr_i    : clear accrued flags (CSR write)
//   fflags_o        : sticky accrued exception flags
//   busy_o          : at least one op in flight
//   perf_stall_o    : cycles with a valid op held back by a stall
//   perf_retired_o  : retire handshakes
//   dbg_busy_o      : scoreboard state, index = {rd_int, rd}
// Optional feature macro: SNITCH_FPU_ISSUE_PERF_EN enables the two 32-bit
// wrapping perf counters; without it both ports are tied to zero.
module snitch_fpu_issue
  import snitch_pkg::*;
#(
  parameter int unsigned FLEN           = 64,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  snitch_fpu_issue_if.master  bus,
  input  logic                fflags_clr_i,
  output logic [4:0]          fflags_o,
  output logic                busy_o,
  output logic [31:0]         perf_stall_o,
  output logic [31:0]         perf_retired_o,
  output logic [63:0]         dbg_busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] OutMax = CntW'(MaxOutstanding);

  logic            stall, hazard;
  logic            issue_hs, rsp_hs, retire, tag_busy;
  fpu_tag_t        issue_tag, rsp_tag;
  logic [FLEN-1:0] rsp_result;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [4:0]      fflags_q, fflags_d;

  assign issue_tag  = '{rd_int: bus.acc_rd_int, rd: bus.acc_rd};
  assign rsp_tag    = bus.fpu_rsp_tag;
  assign rsp_result = bus.fpu_result;

  snitch_fpu_scoreboard i_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (issue_hs),
    .set_tag_i  (issue_tag),
    .clr_i      (retire),
    .clr_tag_i  (rsp_tag),
    .rs_i       (bus.acc_rs),
    .rs_fp_i    (bus.acc_rs_fp),
    .dst_i      (issue_tag),
    .hazard_o   (hazard),
    .clr_busy_o (tag_busy),
    .busy_o     (dbg_busy_o)
  );

  // Issue path is a pure pass-through gated by the stall condition.
  assign stall             = hazard | (outstanding_q == OutMax);
  assign bus.fpu_req_valid = bus.acc_valid & ~stall;
  assign bus.acc_ready     = bus.fpu_req_ready & ~stall;
  assign bus.fpu_req       = bus.acc_op;
  assign bus.fpu_operands  = bus.acc_operands;
  assign bus.fpu_req_tag   = issue_tag;
  assign issue_hs          = bus.acc_valid & bus.acc_ready;

  // FP results always land in the regfile; integer results wait for the core.
  assign bus.fpr_we        = bus.fpu_rsp_valid & ~rsp_tag.rd_int;
  assign bus.fpr_waddr     = rsp_tag.rd;
  assign bus.fpr_wdata     = rsp_result;
  assign bus.int_valid     = bus.fpu_rsp_valid & rsp_tag.rd_int;
  assign bus.int_waddr     = rsp_tag.rd;
  assign bus.int_wdata     = rsp_result[31:0];
  assign bus.fpu_rsp_ready = rsp_tag.rd_int ? bus.int_ready : 1'b1;
  assign rsp_hs            = bus.fpu_rsp_valid & bus.fpu_rsp_ready;

  // A response for an idle tag is a protocol violation: bookkeeping ignores it.
  assign retire = rsp_hs & tag_busy;

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({issue_hs, retire})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // A clear coinciding with a retire keeps the new flags and drops the old.
  always_comb begin
    fflags_d = fflags_q;
    if (fflags_clr_i)  fflags_d = retire ? bus.fpu_status : 5'b0;
    else if (retire)   fflags_d = fflags_q | bus.fpu_status;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      fflags_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      fflags_q      <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;
  assign busy_o   = (outstanding_q != '0);

  retire_tag_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_hs |-> tag_busy)
    else $error("retire of tag %0h with no pending op", rsp_tag);

`ifdef SNITCH_FPU_ISSUE_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_retired_q, perf_retired_d;

  always_comb begin
    perf_stall_d   = perf_stall_q + {31'b0, bus.acc_valid & stall};
    perf_retired_d = perf_retired_q + {31'b0, retire};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q   <= '0;
      perf_retired_q <= '0;
    end else begin
      perf_stall_q   <= perf_stall_d;
      perf_retired_q <= perf_retired_d;
    end
  end

  assign perf_stall_o   = perf_stall_q;
  assign perf_retired_o = perf_retired_q;
`else
  assign perf_stall_o   = 32'b0;
  assign perf_retired_o = 32'b0;
`endif

endmodule
